// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard unit.
//   - FSM state encodings used by hazard_unit (RUN, LD_STALL, FLUSH)
//   - width of the multiply/divide busy counter
//   - saturating increment helper for the stall statistics counter
package hazard_unit_pkg;

    localparam int unsigned CNT_W = 6;

    typedef logic [1:0] state_t;

    localparam state_t RUN      = 2'd0;
    localparam state_t LD_STALL = 2'd1;
    localparam state_t FLUSH    = 2'd2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/muldiv_busy_ctr.sv
// Multiply/divide occupancy counter.
// Loads MULDIV_LAT-1 when a multiply/divide issues and counts down to zero;
// busy is high while the count is nonzero. A start always reloads, even in the
// cycle the count would reach zero, so back-to-back operations leave no gap.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-low
//   start - multiply/divide issuing from EX
//   busy  - HI/LO still being produced
module muldiv_busy_ctr
    import hazard_unit_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = CNT_W'(MULDIV_LAT - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, branch/jump flush, HI/LO interlock.
// Event priority: branch flush > load-use stall > muldiv stall > jump flush.
// Optional muldiv tracking is compiled only when HAZARD_MULDIV_EN is defined;
// otherwise MulDiv_busy is tied low and the muldiv inputs are ignored.
// Ports:
//   clk, reset                       - clock, synchronous active-low reset
//   Read_register1/2_IFID, Uses_rt_IFID - source registers of the ID instruction
//   MemRead_IDEX, Write_Register_IDEX    - load in EX and its destination
//   Branch_taken_EX, Jump_ID             - control-flow redirects
//   MulDiv_start_IDEX, HiLo_read_IFID    - muldiv issue / HI/LO consumer in ID
//   PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble - pipeline control
//   MulDiv_busy, Stall_count             - busy flag, saturating stall cycles
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Read_register1_IFID,
    input  logic [4:0]  Read_register2_IFID,
    input  logic        Uses_rt_IFID,
    input  logic        MemRead_IDEX,
    input  logic [4:0]  Write_Register_IDEX,
    input  logic        Branch_taken_EX,
    input  logic        Jump_ID,
    input  logic        MulDiv_start_IDEX,
    input  logic        HiLo_read_IFID,
    output logic        PC_Write,
    output logic        IFID_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Bubble,
    output logic        MulDiv_busy,
    output logic [15:0] Stall_count
);

    state_t      state_q;
    state_t      state_d;
    logic        load_use;
    logic        hilo_stall;
    logic [15:0] stall_count_q;

`ifdef HAZARD_MULDIV_EN
    muldiv_busy_ctr #(
        .MULDIV_LAT(MULDIV_LAT)
    ) u_busy_ctr (
        .clk  (clk),
        .reset(reset),
        .start(MulDiv_start_IDEX),
        .busy (MulDiv_busy)
    );

    assign hilo_stall = MulDiv_busy & HiLo_read_IFID;
`else
    logic unused_muldiv;
    assign unused_muldiv = ^{MulDiv_start_IDEX, HiLo_read_IFID, MULDIV_LAT};
    assign MulDiv_busy   = 1'b0;
    assign hilo_stall    = 1'b0;
`endif

    // $0 is never a real dependency; rt only counts when the ID instruction reads it.
    assign load_use = MemRead_IDEX && (Write_Register_IDEX != 5'd0) &&
                      ((Write_Register_IDEX == Read_register1_IFID) ||
                       (Uses_rt_IFID && (Write_Register_IDEX == Read_register2_IFID)));

    always_comb begin
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        state_d     = RUN;
        if (!reset) begin
            state_d = RUN;
        end else if (Branch_taken_EX) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
            state_d     = FLUSH;
        end else if (load_use && (state_q == RUN)) begin
            // In LD_STALL the match is stale: the bubble already separates the pair.
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
            state_d     = LD_STALL;
        end else if (hilo_stall) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end else if (Jump_ID && (state_q != FLUSH)) begin
            // After a branch flush the ID slot holds a squashed instruction.
            IFID_Flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= RUN;
            stall_count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (!PC_Write) begin
                stall_count_q <= sat_inc16(stall_count_q);
            end
        end
    end

    assign Stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// stimulus against a behavioural model built on event history flags.
// Muldiv scenarios follow HAZARD_MULDIV_EN.
module tb_hazard_unit;

    localparam int unsigned LAT = 4;

    logic        clk;
    logic        reset;
    logic [4:0]  Read_register1_IFID;
    logic [4:0]  Read_register2_IFID;
    logic        Uses_rt_IFID;
    logic        MemRead_IDEX;
    logic [4:0]  Write_Register_IDEX;
    logic        Branch_taken_EX;
    logic        Jump_ID;
    logic        MulDiv_start_IDEX;
    logic        HiLo_read_IFID;
    logic        PC_Write;
    logic        IFID_Write;
    logic        IFID_Flush;
    logic        IDEX_Bubble;
    logic        MulDiv_busy;
    logic [15:0] Stall_count;

    logic [3:0]  ctl;
    assign ctl = {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble};

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: what happened last cycle, remaining muldiv occupancy, stall total.
    bit   m_prev_ld;
    bit   m_prev_br;
    int   m_busy;
    int   m_stall;
    logic exp_pc, exp_ifw, exp_flush, exp_bub;

    hazard_unit #(
        .MULDIV_LAT(LAT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .Read_register1_IFID(Read_register1_IFID),
        .Read_register2_IFID(Read_register2_IFID),
        .Uses_rt_IFID       (Uses_rt_IFID),
        .MemRead_IDEX       (MemRead_IDEX),
        .Write_Register_IDEX(Write_Register_IDEX),
        .Branch_taken_EX    (Branch_taken_EX),
        .Jump_ID            (Jump_ID),
        .MulDiv_start_IDEX  (MulDiv_start_IDEX),
        .HiLo_read_IFID     (HiLo_read_IFID),
        .PC_Write           (PC_Write),
        .IFID_Write         (IFID_Write),
        .IFID_Flush         (IFID_Flush),
        .IDEX_Bubble        (IDEX_Bubble),
        .MulDiv_busy        (MulDiv_busy),
        .Stall_count        (Stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_load_use();
        return MemRead_IDEX && (Write_Register_IDEX != 0) &&
               (Write_Register_IDEX == Read_register1_IFID ||
                (Uses_rt_IFID && Write_Register_IDEX == Read_register2_IFID));
    endfunction

    task automatic model_eval();
        exp_pc = 1; exp_ifw = 1; exp_flush = 0; exp_bub = 0;
        if (!reset) begin
            // defaults while in reset
        end else if (Branch_taken_EX) begin
            exp_flush = 1; exp_bub = 1;
        end else if (m_load_use() && !m_prev_ld && !m_prev_br) begin
            exp_pc = 0; exp_ifw = 0; exp_bub = 1;
        end else if (m_busy > 0 && HiLo_read_IFID) begin
            exp_pc = 0; exp_ifw = 0; exp_bub = 1;
        end else if (Jump_ID && !m_prev_br) begin
            exp_flush = 1;
        end
    endtask

    task automatic model_update();
        bit new_ld;
        if (!reset) begin
            m_prev_ld = 0; m_prev_br = 0; m_busy = 0; m_stall = 0;
        end else begin
            new_ld = !Branch_taken_EX && m_load_use() && !m_prev_ld && !m_prev_br;
            m_prev_br = Branch_taken_EX;
            m_prev_ld = new_ld;
`ifdef HAZARD_MULDIV_EN
            if (MulDiv_start_IDEX) m_busy = LAT - 1;
            else if (m_busy > 0) m_busy = m_busy - 1;
`endif
            if (!exp_pc && m_stall < 65535) m_stall = m_stall + 1;
        end
    endtask

    // Advance one clock: model sees the same inputs the DUT samples.
    task automatic step();
        model_eval();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 1; Read_register1_IFID = 0; Read_register2_IFID = 0; Uses_rt_IFID = 0;
        MemRead_IDEX = 0; Write_Register_IDEX = 0; Branch_taken_EX = 0; Jump_ID = 0;
        MulDiv_start_IDEX = 0; HiLo_read_IFID = 0;
    endtask

    task automatic load_use_on(input logic [4:0] r);
        MemRead_IDEX = 1; Write_Register_IDEX = r; Read_register1_IFID = r;
    endtask

    task automatic test_reset();
        idle();
        reset = 0;
        load_use_on(5'd8);
        Branch_taken_EX = 1; Jump_ID = 1; HiLo_read_IFID = 1; MulDiv_start_IDEX = 1;
        #1;
        n_cmp++;
        if (ctl !== 4'b1100) begin
            n_fail++; $display("FAIL reset_ctl: got %b want 1100", ctl);
        end
        step();
        n_cmp++;
        if (Stall_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_stall_count: got %0d want 0", Stall_count);
        end
        n_cmp++;
        if (MulDiv_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", MulDiv_busy);
        end
        idle();
        #1;
        n_cmp++;
        if (ctl !== 4'b1100) begin
            n_fail++; $display("FAIL idle_ctl: got %b want 1100", ctl);
        end
        step();
    endtask

    task automatic test_load_use();
        idle();
        load_use_on(5'd8);
        #1;
        n_cmp++;
        if (ctl !== 4'b0001) begin
            n_fail++; $display("FAIL ld_use_stall: got %b want 0001", ctl);
        end
        step();
        #1;
        n_cmp++;
        if (ctl !== 4'b1100) begin
            n_fail++; $display("FAIL ld_use_release: got %b want 1100", ctl);
        end
        n_cmp++;
        if (Stall_count !== 16'd1) begin
            n_fail++; $display("FAIL ld_use_count: got %0d want 1", Stall_count);
        end
        step();
        idle();
        #1;
        n_cmp++;
        if (ctl !== 4'b1100 || Stall_count !== 16'd1) begin
            n_fail++; $display("FAIL ld_use_after: got %b/%0d want 1100/1", ctl, Stall_count);
        end
        step();
    endtask

    task automatic test_no_stall_cases();
        idle();
        MemRead_IDEX = 1; Write_Register_IDEX = 0; Read_register1_IFID = 0;
        #1;
        n_cmp++;
        if (ctl !== 4'b1100) begin
            n_fail++; $display("FAIL ld_r0: got %b want 1100", ctl);
        end
        step();
        Write_Register_IDEX = 5; Read_register1_IFID = 1; Read_register2_IFID = 5;
        Uses_rt_IFID = 0;
        #1;
        n_cmp++;
        if (ctl !== 4'b1100) begin
            n_fail++; $display("FAIL ld_rt_unused: got %b want 1100", ctl);
        end
        step();
        Uses_rt_IFID = 1;
        #1;
        n_cmp++;
        if (ctl !== 4'b0001) begin
            n_fail++; $display("FAIL ld_rt_used: got %b want 0001", ctl);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_branch_priority();
        idle();
        load_use_on(5'd8);
        Branch_taken_EX = 1;
        #1;
        n_cmp++;
        if (ctl !== 4'b1111) begin
            n_fail++; $display("FAIL br_over_ld: got %b want 1111", ctl);
        end
        step();
        Branch_taken_EX = 0; Jump_ID = 1;
        #1;
        n_cmp++;
        if (ctl !== 4'b1100) begin
            n_fail++; $display("FAIL flush_suppress: got %b want 1100", ctl);
        end
        step();
        idle();
        Jump_ID = 1;
        #1;
        n_cmp++;
        if (ctl !== 4'b1110) begin
            n_fail++; $display("FAIL jump_flush: got %b want 1110", ctl);
        end
        step();
        load_use_on(5'd9);
        #1;
        n_cmp++;
        if (ctl !== 4'b0001) begin
            n_fail++; $display("FAIL ld_over_jump: got %b want 0001", ctl);
        end
        step();
        idle();
        step();
    endtask

`ifdef HAZARD_MULDIV_EN
    task automatic test_muldiv();
        int base;
        idle();
        MulDiv_start_IDEX = 1; HiLo_read_IFID = 1;
        #1;
        n_cmp++;
        if (ctl !== 4'b1100 || MulDiv_busy !== 1'b0) begin
            n_fail++; $display("FAIL md_start: got %b/%b want 1100/0", ctl, MulDiv_busy);
        end
        step();
        base = m_stall;
        MulDiv_start_IDEX = 0;
        for (int i = 0; i < int'(LAT) - 1; i++) begin
            #1;
            n_cmp++;
            if (ctl !== 4'b0001 || MulDiv_busy !== 1'b1) begin
                n_fail++; $display("FAIL md_stall%0d: got %b/%b want 0001/1", i, ctl, MulDiv_busy);
            end
            step();
        end
        #1;
        n_cmp++;
        if (ctl !== 4'b1100 || MulDiv_busy !== 1'b0 || Stall_count !== 16'(base + 3)) begin
            n_fail++;
            $display("FAIL md_done: got %b/%b/%0d want 1100/0/%0d", ctl, MulDiv_busy,
                     Stall_count, base + 3);
        end
        // Restart on the last busy cycle: busy must stay high with no gap.
        idle();
        MulDiv_start_IDEX = 1;
        step();
        MulDiv_start_IDEX = 0;
        for (int i = 0; i < 6; i++) begin
            MulDiv_start_IDEX = (i == 2);
            #1;
            n_cmp++;
            if (MulDiv_busy !== 1'b1) begin
                n_fail++; $display("FAIL md_chain%0d: got %b want 1", i, MulDiv_busy);
            end
            step();
        end
        idle();
        #1;
        n_cmp++;
        if (MulDiv_busy !== 1'b0) begin
            n_fail++; $display("FAIL md_chain_end: got %b want 0", MulDiv_busy);
        end
        step();
    endtask
`else
    task automatic test_muldiv();
        idle();
        MulDiv_start_IDEX = 1;
        step();
        MulDiv_start_IDEX = 0; HiLo_read_IFID = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (ctl !== 4'b1100 || MulDiv_busy !== 1'b0) begin
                n_fail++; $display("FAIL md_off%0d: got %b/%b want 1100/0", i, ctl, MulDiv_busy);
            end
            step();
        end
        idle();
        step();
    endtask
`endif

    task automatic test_reset_midstall();
        idle();
        load_use_on(5'd12);
        MulDiv_start_IDEX = 1;
        #1;
        n_cmp++;
        if (ctl !== 4'b0001) begin
            n_fail++; $display("FAIL mid_stall: got %b want 0001", ctl);
        end
        step();
        MulDiv_start_IDEX = 0; HiLo_read_IFID = 1; reset = 0;
        #1;
        n_cmp++;
        if (ctl !== 4'b1100) begin
            n_fail++; $display("FAIL mid_reset_ctl: got %b want 1100", ctl);
        end
        step();
        idle();
        HiLo_read_IFID = 1;
        #1;
        n_cmp++;
        if (ctl !== 4'b1100 || Stall_count !== 16'd0 || MulDiv_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: got %b/%0d/%b want 1100/0/0", ctl, Stall_count, MulDiv_busy);
        end
        step();
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset               = ($urandom_range(0, 39) != 0);
            Read_register1_IFID = 5'($urandom_range(0, 3));
            Read_register2_IFID = 5'($urandom_range(0, 3));
            Write_Register_IDEX = 5'($urandom_range(0, 3));
            Uses_rt_IFID        = 1'($urandom_range(0, 1));
            MemRead_IDEX        = 1'($urandom_range(0, 1));
            Branch_taken_EX     = ($urandom_range(0, 6) == 0);
            Jump_ID             = ($urandom_range(0, 4) == 0);
            MulDiv_start_IDEX   = ($urandom_range(0, 9) == 0);
            HiLo_read_IFID      = ($urandom_range(0, 2) == 0);
            #1;
            model_eval();
            n_cmp++;
            if ({PC_Write, IFID_Write} !== {exp_pc, exp_ifw}) begin
                n_fail++;
                $display("FAIL rnd_pc_ifw cycle %0d: got %b%b want %b%b", i, PC_Write, IFID_Write,
                         exp_pc, exp_ifw);
            end
            n_cmp++;
            if (IFID_Flush !== exp_flush) begin
                n_fail++; $display("FAIL rnd_flush cycle %0d: got %b want %b", i, IFID_Flush, exp_flush);
            end
            n_cmp++;
            if (IDEX_Bubble !== exp_bub) begin
                n_fail++; $display("FAIL rnd_bubble cycle %0d: got %b want %b", i, IDEX_Bubble, exp_bub);
            end
            n_cmp++;
            if (MulDiv_busy !== (m_busy > 0)) begin
                n_fail++; $display("FAIL rnd_busy cycle %0d: got %b want %b", i, MulDiv_busy, m_busy > 0);
            end
            n_cmp++;
            if (Stall_count !== 16'(m_stall)) begin
                n_fail++; $display("FAIL rnd_count cycle %0d: got %0d want %0d", i, Stall_count, m_stall);
            end
            step();
        end
        idle();
        step();
    endtask

`ifdef HAZARD_MULDIV_EN
    task automatic test_saturation();
        idle();
        MulDiv_start_IDEX = 1; HiLo_read_IFID = 1;
        for (int i = 0; i < 70001; i++) step();
        #1;
        n_cmp++;
        if (Stall_count !== 16'hFFFF || PC_Write !== 1'b0) begin
            n_fail++; $display("FAIL sat_count: got %h/%b want ffff/0", Stall_count, PC_Write);
        end
        step();
        #1;
        n_cmp++;
        if (Stall_count !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_hold: got %h want ffff", Stall_count);
        end
        idle();
        step();
    endtask
`else
    // Load-use stalls at most every other cycle, so saturation is out of reach
    // within a short run; check the exact accumulation instead.
    task automatic test_saturation();
        idle();
        load_use_on(5'd3);
        for (int i = 0; i < 4000; i++) step();
        #1;
        n_cmp++;
        if (Stall_count !== 16'(m_stall)) begin
            n_fail++; $display("FAIL long_count: got %0d want %0d", Stall_count, m_stall);
        end
        idle();
        step();
    endtask
`endif

    initial begin
        m_prev_ld = 0; m_prev_br = 0; m_busy = 0; m_stall = 0;
        idle();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_no_stall_cases();
        test_branch_priority();
        test_muldiv();
        test_reset_midstall();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
